// File: rtl/checkpoint_ctrl_if.sv
// checkpoint_ctrl_if: branch dispatch/resolve/commit bundle and checkpoint table strobes
interface checkpoint_ctrl_if #(parameter int CP_INDEX_SIZE = 2);
  logic                     br_alloc;
  logic                     br_alloc_ready;
  logic [CP_INDEX_SIZE-1:0] br_tag;
  logic                     check;
  logic [CP_INDEX_SIZE-1:0] check_idx;
  logic                     br_resolve;
  logic [CP_INDEX_SIZE-1:0] br_resolve_tag;
  logic                     br_mispredict;
  logic                     recover;
  logic [CP_INDEX_SIZE-1:0] recover_idx;
  logic                     br_commit;
  logic [CP_INDEX_SIZE:0]   cp_count;
  logic                     cp_full;
  logic                     cp_empty;
  logic                     protocol_err;
  modport master (
    output br_alloc, br_resolve, br_resolve_tag, br_mispredict, br_commit,
    input  br_alloc_ready, br_tag, check, check_idx, recover, recover_idx,
           cp_count, cp_full, cp_empty, protocol_err
  );
  modport slave (
    input  br_alloc, br_resolve, br_resolve_tag, br_mispredict, br_commit,
    output br_alloc_ready, br_tag, check, check_idx, recover, recover_idx,
           cp_count, cp_full, cp_empty, protocol_err
  );
endinterface

// File: rtl/checkpoint_ctrl.sv
// checkpoint_ctrl: allocates, frees and squashes RAT checkpoint slots as a circular buffer
module checkpoint_ctrl #(
  parameter int CP_SIZE       = 4,
  parameter int CP_INDEX_SIZE = 2
) (
  input logic              clock,
  input logic              reset,
  checkpoint_ctrl_if.slave bus
);
  localparam int CW = CP_INDEX_SIZE + 1;
  typedef enum logic {IDLE, RECOVER} state_t;
  state_t                   state;
  logic [CP_INDEX_SIZE-1:0] head, tail, last_idx, t, dist_t;
  logic [CW-1:0]            count;
  logic [CP_SIZE-1:0]       valid, keep;
  logic                     mp, acc, bad, alloc, commit, cmt_err, err;
  assign t       = bus.br_resolve_tag;
  assign mp      = bus.br_resolve & bus.br_mispredict;
  assign acc     = !reset & mp & valid[t];
  assign bad     = mp & !valid[t];
  assign commit  = bus.br_commit & valid[head];
  assign cmt_err = bus.br_commit & (count == '0);
  assign dist_t  = t - head;
  assign bus.cp_count       = count;
  assign bus.cp_full        = count == CW'(CP_SIZE);
  assign bus.cp_empty       = count == '0;
  assign bus.protocol_err   = err;
  assign bus.br_alloc_ready = !reset & (state == IDLE) & !bus.cp_full & !mp;
  assign alloc              = bus.br_alloc & bus.br_alloc_ready;
  assign bus.check          = alloc;
  assign bus.check_idx      = tail;
  assign bus.br_tag         = tail;
  assign bus.recover        = acc;
  assign bus.recover_idx    = acc ? t : last_idx;
  // A slot survives a squash if it is no younger than t, measured from head.
  always_comb begin
    keep = '0;
    for (int i = 0; i < CP_SIZE; i++)
      keep[i] = (CP_INDEX_SIZE'(i) - head) <= dist_t;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      last_idx <= '0;
      err      <= 1'b0;
    end else begin
      state <= acc ? RECOVER : IDLE;
      err   <= err | bad | cmt_err;
      head  <= head + CP_INDEX_SIZE'(commit);
      if (acc) begin
        last_idx <= t;
        tail     <= t + CP_INDEX_SIZE'(1);
        count    <= CW'(dist_t) + CW'(1) - CW'(commit);
        valid    <= valid & keep & ~(CP_SIZE'(commit) << head);
      end else begin
        tail  <= tail + CP_INDEX_SIZE'(alloc);
        count <= count + CW'(alloc) - CW'(commit);
        valid <= (valid | (CP_SIZE'(alloc) << tail)) & ~(CP_SIZE'(commit) << head);
      end
    end
  end
endmodule
